// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready request and result handshakes
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             Zero,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [2:0] op;
  logic neg_q, neg_r;
  logic [WIDTH-1:0] acc, lo, m;
  logic a_neg, b_neg, b_zero, ovf, mul_zero, special;
  logic [WIDTH-1:0] a_mag, b_mag, spec_res, q_f, r_f, fix_res;
  logic [WIDTH:0] mul_sum, div_t, div_d;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_f;
  always_comb begin
    a_neg = A[WIDTH-1] & ~(funct3[0] & (funct3[1] | funct3[2]));
    b_neg = B[WIDTH-1] & (funct3[2] ? ~funct3[0] : ~funct3[1]);
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
    b_zero = B == '0;
    ovf = funct3[2] & ~funct3[0] & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (&B);
    mul_zero = ~funct3[2] & ((A == '0) | b_zero);
    special = (funct3[2] & b_zero) | ovf | mul_zero;
    spec_res = mul_zero ? '0 : b_zero ? (funct3[1] ? A : '1) : (funct3[1] ? '0 : A);
    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, m} : '0);
    mul_next = {mul_sum, lo[WIDTH-1:1]};
    div_t = {acc, lo[WIDTH-1]};
    div_d = div_t - {1'b0, m};
    div_next = {div_d[WIDTH] ? div_t[WIDTH-1:0] : div_d[WIDTH-1:0], lo[WIDTH-2:0], ~div_d[WIDTH]};
    prod_f = neg_q ? -{acc, lo} : {acc, lo};
    q_f = neg_q ? -lo : lo;
    r_f = neg_r ? -acc : acc;
    fix_res = op == 3'd0 ? prod_f[WIDTH-1:0] : !op[2] ? prod_f[2*WIDTH-1:WIDTH] : op[1] ? r_f : q_f;
  end
  // acc/lo hold {product hi, lo} for multiply and {remainder, quotient} for divide;
  // cnt starts at all-ones so CALC spends one load cycle before its WIDTH radix-2 steps
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      result <= '0;
      Zero <= 1'b0;
    end else if (state == IDLE) begin
      if (req_valid) begin
        op <= funct3;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        m <= funct3[2] ? b_mag : a_mag;
        lo <= funct3[2] ? a_mag : b_mag;
        acc <= '0;
        cnt <= '1;
        state <= special ? DONE : CALC;
        if (special) begin
          result <= spec_res;
          Zero <= spec_res == '0;
        end
      end
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      if (cnt != '1) {acc, lo} <= op[2] ? div_next : mul_next;
      if (cnt == CW'(WIDTH-1)) state <= FIX;
    end else if (state == FIX) begin
      result <= fix_res;
      Zero <= fix_res == '0;
      state <= DONE;
    end else if (result_ready) state <= IDLE;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign result_valid = state == DONE;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table, hand-written handshake/reset sequences and random ops against an arithmetic model
module tb_muldiv_unit;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, result_ready = 1'b0;
  logic [2:0] funct3 = 3'd0;
  logic [W-1:0] A = '0, B = '0;
  logic [W-1:0] result;
  logic Zero, result_valid, req_ready, busy;
  int tests = 0, fails = 0;

  typedef struct {
    logic [2:0] f;
    logic [31:0] a, b, res;
    logic z;
    int lat;
  } vec_t;
  vec_t vecs[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .funct3(funct3),
    .A(A), .B(B), .result(result), .Zero(Zero), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p = '0;
    if (f == 3'd0 || f == 3'd1) p = sa * sb;
    else if (f == 3'd2) p = sa * ub;
    else if (f == 3'd3) p = ua * ub;
    else if (b == 0) p = f[1] ? ua : '1;
    else if (f == 3'd4) p = sa / sb;
    else if (f == 3'd5) p = ua / ub;
    else if (f == 3'd6) p = sa % sb;
    else p = ua % ub;
    return (f == 3'd0 || f[2]) ? p[31:0] : p[63:32];
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic sp;
    sp = (f[2] && b == 0) || ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF)
         || (!f[2] && (a == 0 || b == 0));
    return sp ? 1 : W + 2;
  endfunction

  function automatic logic [31:0] pick(input int cls);
    logic [31:0] edges [5];
    edges = '{32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h7FFFFFFF};
    if (cls == 0) return $urandom();
    if (cls == 1) return 32'(int'($urandom_range(0, 16)) - 8);
    if (cls == 2) return 32'h0;
    return edges[$urandom_range(0, 4)];
  endfunction

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic z, output int lat);
    int k;
    @(negedge clk);
    funct3 = f; A = a; B = b; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    A = $urandom();
    B = $urandom();
    funct3 = 3'($urandom());
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!result_valid && k < 100);
    lat = result_valid ? k : -1;
    r = result;
    z = Zero;
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r, a, b;
    logic z;
    logic [2:0] f;
    int lat, seen;
    vecs.push_back('{3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34});
    vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34});
    vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 34});
    vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 34});
    vecs.push_back('{3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 34});
    vecs.push_back('{3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 34});
    vecs.push_back('{3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, 1});
    vecs.push_back('{3'd6, 32'd5, 32'd0, 32'd5, 1'b0, 1});
    vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1});
    vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1, 1});
    vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 34});
    vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 34});
    vecs.push_back('{3'd0, 32'd0, 32'd5, 32'd0, 1'b1, 1});
    vecs.push_back('{3'd7, 32'd6, 32'd3, 32'd0, 1'b1, 34});

    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset result_valid", 32'(result_valid), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset Zero", 32'(Zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, r, z, lat);
      chk($sformatf("vec%0d result", i), r, vecs[i].res);
      chk($sformatf("vec%0d Zero", i), 32'(z), 32'(vecs[i].z));
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d idle after consume", i), 32'({result_valid, req_ready}), 32'd1);
    end

    @(negedge clk);
    funct3 = 3'd0; A = 32'd7; B = 32'hFFFFFFFD; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen = 0;
    while (!result_valid && seen < 100) begin
      @(posedge clk);
      #1;
      seen++;
    end
    chk("bp result_valid", 32'(result_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      funct3 = 3'd5; A = 32'd100; B = 32'd7; req_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("bp hold %0d result", i), result, 32'hFFFFFFEB);
      chk($sformatf("bp hold %0d flags", i), 32'({result_valid, req_ready}), 32'd2);
    end
    @(negedge clk);
    req_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    chk("bp consume busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (busy) seen++;
    end
    chk("bp not queued", seen, 0);
    do_op(3'd5, 32'd100, 32'd7, r, z, lat);
    chk("bp next op result", r, 32'd14);

    @(negedge clk);
    funct3 = 3'd4; A = 32'hFFFFFFF9; B = 32'd2; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset flags", 32'({busy, req_ready, result_valid}), 32'd2);
    chk("midreset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (result_valid) seen++;
    end
    chk("midreset no result", seen, 0);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom());
      a = pick($urandom_range(0, 3));
      b = pick($urandom_range(0, 3));
      do_op(f, a, b, r, z, lat);
      chk($sformatf("rand%0d f%0d %h,%h result", i, f, a, b), r, model(f, a, b));
      chk($sformatf("rand%0d Zero", i), 32'(z), 32'(model(f, a, b) == 0));
      chk($sformatf("rand%0d latency", i), lat, model_lat(f, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
